// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the pulse width meter.
package pwm_pkg;

  localparam int unsigned DefaultCntW  = 16;
  localparam int unsigned DefaultDepth = 4;

  typedef enum logic {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_fifo.sv
// Show-ahead FIFO: rdata_o presents the head entry (zero when empty), pop consumes it.
module pwm_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [PtrW:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the duration of each level of an asynchronous signal in clk cycles and
// queues {level, width} records into a show-ahead FIFO with sticky overflow.
module pulse_width_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  input  logic                   en,
  input  logic                   clr_ovf,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_level,
  output logic [CNT_W-1:0]       m_width,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ovf,
  output logic                   busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync2_q, lvl_q;
  logic               ovf_q, ovf_d;
  logic               sig_edge, push, pop, full, empty, drop;
  logic [CNT_W:0]     fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      lvl_q   <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sig_edge = (sync2_q != lvl_q);

  // The first edge only arms the counter: the preceding level has an unknown start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && sig_edge) begin
          state_d = StMeasure;
          cnt_d   = CNT_W'(1);
        end
      end
      StMeasure: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sig_edge) begin
          push  = 1'b1;
          cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop  = m_valid && m_ready;
  assign drop = push && full && !pop;

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  pwm_fifo #(
    .Width(CNT_W + 1),
    .Depth(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i({lvl_q, cnt_q}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count),
    .full_o (full),
    .empty_o(empty)
  );

  assign m_valid = !empty;
  assign m_level = fifo_rdata[CNT_W];
  assign m_width = fifo_rdata[CNT_W-1:0];
  assign ovf     = ovf_q;
  assign busy    = (state_q == StMeasure);

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width-counter and m_width bit width.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2), SHALL set the measurement FIFO entry count.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be an asynchronous, active-high reset.
REQ-005 Port sig_in, input, 1, SHALL be the asynchronous monitored level, i.e. the inverter-chain output.
REQ-006 Port en, input, 1, SHALL enable measurement when high.
REQ-007 Port clr_ovf, input, 1, SHALL clear the overflow flag when high for one cycle.
REQ-008 Port m_valid, output, 1, SHALL indicate a measurement is presented.
REQ-009 Port m_ready, input, 1, SHALL indicate the consumer accepts the presented measurement.
REQ-010 Port m_level, output, 1, SHALL give the level (0/1) of the measured pulse.
REQ-011 Port m_width, output, CNT_W, SHALL give the pulse duration in clk cycles.
REQ-012 Port fifo_count, output, $clog2(DEPTH)+1, SHALL give the stored entry count.
REQ-013 Port ovf, output, 1, SHALL be a sticky flag marking a dropped measurement.
REQ-014 Port busy, output, 1, SHALL be high while the FSM is in MEASURE.

Function
REQ-015 sig_in SHALL pass a 2-flop synchronizer (sync1, sync2), then a delay flop lvl_q; edge = sync2 != lvl_q.
REQ-016 FSM states SHALL be IDLE and MEASURE.
REQ-017 IDLE -> MEASURE SHALL occur on the first edge with en=1; no measurement is pushed, because the start is unknown.
REQ-018 MEASURE -> IDLE SHALL occur whenever en=0; cnt is cleared and no push occurs.
REQ-019 On an edge in MEASURE, the block SHALL push {lvl_q, cnt} and load cnt=1; otherwise cnt SHALL increment.
REQ-020 On entering MEASURE, cnt SHALL load 1.
REQ-021 cnt SHALL saturate at 2^CNT_W-1 and never wrap; the saturated value is pushed as-is.
REQ-022 A level held N sampled cycles SHALL yield m_width=N; the minimum is 1.
REQ-023 The FIFO SHALL be show-ahead: m_valid = (count != 0); m_level/m_width show the head entry; a pop occurs when m_valid & m_ready.
REQ-024 A sig_in change captured by sync1 at edge k SHALL be detected in the cycle after edge k+1.
REQ-025 The resulting push SHALL be written at edge k+2.
REQ-026 A push on an empty FIFO SHALL raise m_valid in the cycle after its write edge.
REQ-027 Push to a full FIFO without a pop SHALL be dropped and set ovf=1.
REQ-028 Push and pop on a full FIFO in the same cycle SHALL both succeed, with no drop and count unchanged.
REQ-029 A push and pop on an empty FIFO in the same cycle SHALL be impossible, since m_valid=0.
REQ-030 clr_ovf SHALL clear ovf; a simultaneous drop SHALL win (ovf stays 1).
REQ-031 m_level/m_width SHALL be 0 when m_valid=0.
REQ-032 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 rst SHALL asynchronously set: state=IDLE, cnt=0, sync1=sync2=lvl_q=0, FIFO empty (pointers 0), ovf=0.
REQ-034 Reset outputs SHALL be m_valid=0, m_level=0, m_width=0, fifo_count=0, busy=0.
REQ-035 Reset mid-measurement SHALL discard the partial pulse and all stored entries; after release, the FSM waits in IDLE for a fresh edge.

Structure
REQ-036 Package pwm_pkg SHALL hold the FSM state enum (IDLE, MEASURE) and the default CNT_W/DEPTH constants.
REQ-037 The FIFO SHALL be one sub-module, pwm_fifo (show-ahead, parameterized width/depth, count, full/empty).

Verification
REQ-038 With en=1, sig_in 0->1 at cycle 10, 1->0 at cycle 17, 0->1 at cycle 29 -> two entries {1,7} then {0,12}, first pushed 2 cycles after the sampled change.
REQ-039 With m_ready=0 and DEPTH=4, after 6 level edges -> entries 1..4 kept, the 5th measurement dropped, ovf=1, fifo_count=4; clr_ovf -> ovf=0.
REQ-040 With the FIFO full and m_ready=1, at the same edge as a new push -> no drop, fifo_count stays 4, ovf stays 0.
REQ-041 With CNT_W=4 and sig_in held high for 40 cycles -> m_width=15, m_level=1.
REQ-042 rst asserted mid-pulse with 2 entries stored -> immediate m_valid=0, fifo_count=0, busy=0; the next edge only enters MEASURE, with no push.
REQ-043 en dropped mid-pulse then re-raised -> no push for the interrupted pulse; the first push after re-enable measures from the next edge.
